// File: rtl/bubble_pkg.sv
// bubble_pkg: shared defaults, FSM state encoding and modulo helper for the bubble tracker
package bubble_pkg;
   localparam int LOOP_LEN_DEF = 2053;
   localparam int SHIFT_PERIOD_DEF = 960;
   typedef enum logic [1:0] {ST_IDLE, ST_SHIFTING, ST_STOPPING} state_t;
   function automatic logic [11:0] mod_add(input logic [11:0] a, input logic [11:0] b, input logic [12:0] len);
      logic [12:0] s;
      s = {1'b0, a} + {1'b0, b};
      return (s >= len) ? 12'(s - len) : s[11:0];
   endfunction
endpackage

// File: rtl/bubble_input_sync.sv
// bubble_input_sync: 2-FF synchronizer plus edge register for one async active-low host strobe
module bubble_input_sync (
   input  logic clk,
   input  logic rst,
   input  logic pin_n,
   output logic level_n,
   output logic fall,
   output logic rise
);
   logic [2:0] sr;
   // flops idle high so reset never manufactures an edge
   always_ff @(posedge clk)
      if (rst) sr <= 3'b111;
      else sr <= {sr[1:0], pin_n};
   assign level_n = sr[1];
   assign fall = sr[2] & ~sr[1];
   assign rise = ~sr[2] & sr[1];
endmodule

// File: rtl/bubble_position_tracker.sv
// bubble_position_tracker: tracks minor-loop position of a bubble memory and latches replicate pages
module bubble_position_tracker
   import bubble_pkg::*;
#(
   parameter int SHIFT_PERIOD = SHIFT_PERIOD_DEF,
   parameter int LOOP_LEN = LOOP_LEN_DEF,
   parameter int PAGE_OFFSET = 0
) (
   input  logic        MCLK,
   input  logic        MRST,
   input  logic        nBSEN,
   input  logic        nREPEN,
   input  logic        nBOOTEN,
   output logic [11:0] POSITION,
   output logic [11:0] PAGE,
   output logic        STEP,
   output logic        PAGELOAD,
   output logic        BOOTMODE,
   output logic        SHIFTING,
   output logic        REPERR
);
   localparam int CW = SHIFT_PERIOD > 1 ? $clog2(SHIFT_PERIOD) : 1;
   localparam logic [12:0] LEN = 13'(LOOP_LEN);
   localparam logic [11:0] OFS = 12'(PAGE_OFFSET % LOOP_LEN);
   state_t state, state_nx;
   logic [CW-1:0] cnt;
   logic bsen_level, bsen_fall, bsen_rise;
   logic rep_level, rep_fall, rep_rise;
   logic boot_level, boot_fall, boot_rise;
   logic period_end, rep_act, page_upd;
   logic [11:0] pos_nx;
   logic unused_sync;
   bubble_input_sync u_bsen (.clk(MCLK), .rst(MRST), .pin_n(nBSEN), .level_n(bsen_level), .fall(bsen_fall), .rise(bsen_rise));
   bubble_input_sync u_rep (.clk(MCLK), .rst(MRST), .pin_n(nREPEN), .level_n(rep_level), .fall(rep_fall), .rise(rep_rise));
   bubble_input_sync u_boot (.clk(MCLK), .rst(MRST), .pin_n(nBOOTEN), .level_n(boot_level), .fall(boot_fall), .rise(boot_rise));
   assign unused_sync = ^{bsen_level, rep_level, rep_rise, boot_fall, boot_rise};
   assign SHIFTING = state != ST_IDLE;
   assign period_end = SHIFTING && cnt == CW'(SHIFT_PERIOD - 1);
   assign pos_nx = period_end ? mod_add(POSITION, 12'd1, LEN) : POSITION;
   assign rep_act = rep_fall && SHIFTING;
   // stopping only ends on a period boundary, so no partial step is ever taken
   always_comb begin
      state_nx = state;
      if (state == ST_IDLE && bsen_fall) state_nx = ST_SHIFTING;
      else if (state == ST_SHIFTING && bsen_rise) state_nx = ST_STOPPING;
      else if (state == ST_STOPPING) state_nx = bsen_fall ? ST_SHIFTING : period_end ? ST_IDLE : ST_STOPPING;
   end
   always_ff @(posedge MCLK)
      if (MRST) begin
         state <= ST_IDLE;
         cnt <= '0;
         POSITION <= '0;
         PAGE <= '0;
         STEP <= 1'b0;
         page_upd <= 1'b0;
         PAGELOAD <= 1'b0;
         BOOTMODE <= 1'b0;
         REPERR <= 1'b0;
      end else begin
         state <= state_nx;
         cnt <= (state == ST_IDLE || period_end) ? '0 : cnt + 1'b1;
         POSITION <= pos_nx;
         STEP <= period_end;
         PAGE <= rep_act ? mod_add(pos_nx, OFS, LEN) : PAGE;
         page_upd <= rep_act;
         PAGELOAD <= page_upd;
         BOOTMODE <= (state == ST_IDLE && state_nx == ST_SHIFTING) ? ~boot_level : (state_nx == ST_IDLE) ? 1'b0 : BOOTMODE;
         REPERR <= REPERR | (state == ST_IDLE && rep_fall);
      end
endmodule

// File: tb/tb_bubble_position_tracker.sv
// tb_bubble_position_tracker: directed scoreboard bench for the bubble position tracker
module tb_bubble_position_tracker;
   localparam int P = 16;
   logic MCLK = 1'b0, MRST = 1'b1, nBSEN = 1'b1, nREPEN = 1'b1, nBOOTEN = 1'b1;
   logic [11:0] POSITION, PAGE;
   logic STEP, PAGELOAD, BOOTMODE, SHIFTING, REPERR;
   int checks = 0, errors = 0;
   int exp_steps[$], exp_pages[$];
   always #5 MCLK = ~MCLK;
   bubble_position_tracker #(.SHIFT_PERIOD(P)) dut (
      .MCLK(MCLK), .MRST(MRST), .nBSEN(nBSEN), .nREPEN(nREPEN), .nBOOTEN(nBOOTEN),
      .POSITION(POSITION), .PAGE(PAGE), .STEP(STEP), .PAGELOAD(PAGELOAD),
      .BOOTMODE(BOOTMODE), .SHIFTING(SHIFTING), .REPERR(REPERR)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask
   task automatic tick(input int n);
      repeat (n) @(negedge MCLK);
   endtask
   task automatic wait_idle(input string tag);
      for (int i = 0; i < 4 * P && SHIFTING; i++) @(negedge MCLK);
      chk(tag, SHIFTING, 0);
   endtask
   always @(negedge MCLK)
      if (!MRST) begin
         if (STEP) chk("step_pos", POSITION, exp_steps.size() != 0 ? exp_steps.pop_front() : 'hFFFF);
         if (PAGELOAD) chk("pageload_page", PAGE, exp_pages.size() != 0 ? exp_pages.pop_front() : 'hFFFF);
      end
   initial begin
      tick(3);
      MRST = 1'b0;
      tick(1);
      chk("rst_pos", POSITION, 0);
      chk("rst_page", PAGE, 0);
      chk("rst_step", STEP, 0);
      chk("rst_pageload", PAGELOAD, 0);
      chk("rst_boot", BOOTMODE, 0);
      chk("rst_shift", SHIFTING, 0);
      chk("rst_reperr", REPERR, 0);
      for (int i = 1; i <= 6; i++) exp_steps.push_back(i);
      nBSEN = 1'b0;
      tick(2);
      chk("latency_pre", SHIFTING, 0);
      tick(1);
      chk("latency", SHIFTING, 1);
      tick(5 * P + 10 - 3);
      nBSEN = 1'b1;
      tick(4);
      chk("stopping_active", SHIFTING, 1);
      chk("stopping_pos", POSITION, 5);
      wait_idle("stop_idle");
      chk("stop_pos", POSITION, 6);
      for (int i = 7; i <= 2052; i++) exp_steps.push_back(i);
      exp_steps.push_back(0);
      nBSEN = 1'b0;
      for (int i = 0; i < 2100 * P && !(STEP && POSITION == 0); i++) tick(1);
      chk("wrap_pos", POSITION, 0);
      chk("wrap_step", STEP, 1);
      exp_steps.push_back(1);
      nBSEN = 1'b1;
      wait_idle("wrap_idle");
      chk("wrap_final", POSITION, 1);
      for (int i = 2; i <= 144; i++) exp_steps.push_back(i);
      nBSEN = 1'b0;
      for (int i = 0; i < 120 * P && !(STEP && POSITION == 98); i++) tick(1);
      chk("at98", POSITION, 98);
      tick(29);
      exp_pages.push_back(100);
      nREPEN = 1'b0;
      tick(4);
      nREPEN = 1'b1;
      tick(4);
      exp_pages.push_back(100);
      nREPEN = 1'b0;
      tick(3);
      chk("page_edge3", PAGE, 100);
      chk("pageload_edge3", PAGELOAD, 0);
      tick(1);
      chk("pageload_edge4", PAGELOAD, 1);
      tick(683);
      nREPEN = 1'b1;
      nBSEN = 1'b1;
      wait_idle("rep_idle");
      chk("rep_pos", POSITION, 144);
      nREPEN = 1'b0;
      tick(5);
      nREPEN = 1'b1;
      tick(5);
      chk("reperr_set", REPERR, 1);
      chk("idle_page", PAGE, 100);
      tick(20);
      chk("reperr_sticky", REPERR, 1);
      nBOOTEN = 1'b0;
      tick(4);
      exp_steps.push_back(145);
      exp_steps.push_back(146);
      nBSEN = 1'b0;
      tick(3);
      chk("boot_on", BOOTMODE, 1);
      chk("boot_shift", SHIFTING, 1);
      nBOOTEN = 1'b1;
      tick(20);
      chk("boot_hold", BOOTMODE, 1);
      nBSEN = 1'b1;
      wait_idle("boot_idle");
      chk("boot_clear", BOOTMODE, 0);
      chk("boot_pos", POSITION, 146);
      nBSEN = 1'b0;
      tick(3);
      chk("noboot", BOOTMODE, 0);
      chk("shift2", SHIFTING, 1);
      tick(8);
      MRST = 1'b1;
      nBSEN = 1'b1;
      tick(1);
      chk("mrst_pos", POSITION, 0);
      chk("mrst_page", PAGE, 0);
      chk("mrst_step", STEP, 0);
      chk("mrst_pageload", PAGELOAD, 0);
      chk("mrst_boot", BOOTMODE, 0);
      chk("mrst_shift", SHIFTING, 0);
      chk("mrst_reperr", REPERR, 0);
      MRST = 1'b0;
      tick(25);
      chk("post_rst_shift", SHIFTING, 0);
      chk("post_rst_pos", POSITION, 0);
      chk("steps_drained", exp_steps.size(), 0);
      chk("pages_drained", exp_pages.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
